alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Round-robin controller that shares one registered 48-bit ALU (2-bit select: add, subtract, add-with-C-and-carry, XOR) between NUM_REQ requesters.
- Accepts one operation at a time over a valid/ready handshake and drives the ALU operand and select ports with held, stable values.
- Waits out the ALU pipeline latency, captures P, and returns the result with the requester ID over a valid/ready response channel.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must be at least clog2(NUM_REQ).
- ALU_LAT, 1, clock edges from operands stable at the ALU inputs to P valid (1..4).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester operation valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_op  input  2*NUM_REQ  ALU select per requester (slice i = bits [2i+1:2i]).
- req_a  input  18*NUM_REQ  operand a per requester.
- req_b  input  18*NUM_REQ  operand b per requester.
- req_d  input  18*NUM_REQ  operand d per requester.
- req_c  input  48*NUM_REQ  operand c per requester.
- req_cin  input  NUM_REQ  carry-in per requester.
- alu_a, alu_b, alu_d  output  18 each  operands to the ALU.
- alu_c  output  48  operand to the ALU.
- alu_cin  output  1  carry-in to the ALU.
- alu_select  output  2  ALU select.
- alu_p  input  48  ALU result P.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  ID_W  index of the requester that issued the operation.
- rsp_data  output  48  captured result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE and the RR pointer to 0.
  - All alu_* outputs, rsp_data, rsp_id, rsp_valid and busy go to 0.
  - req_ready is 0 while in reset.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant goes to the first i with req_valid[i]=1, searching from the pointer upward with wrap-around.
  - req_ready[grant]=1 combinationally; all other req_ready bits are 0. No valid request means no grant.
  - On the handshake edge: latch that requester's op/a/b/c/d/cin into the ALU output registers, store rsp_id, set the pointer to (grant+1) mod NUM_REQ, set the counter to 0, and go to EXEC.
- EXEC:
  - alu_* outputs are held stable.
  - The counter increments each cycle. EXEC lasts ALU_LAT+1 cycles.
  - On the last EXEC edge: rsp_data <= alu_p, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are stable; alu_* outputs are still held.
  - On rsp_valid & rsp_ready, go to IDLE and drop rsp_valid.
  - The next request can be accepted no earlier than the following IDLE cycle.
- Latency: rsp_valid rises ALU_LAT+2 cycles after the accept edge.
- Throughput: at most 1 operation per ALU_LAT+3 cycles.
- req_ready is 0 in EXEC and RESP; requesters hold req_valid and their operands until accepted.
- Backpressure: rsp_ready=0 holds RESP indefinitely with all outputs frozen.
- Pointer:
  - Updates only on an accept, never on idle cycles.
  - Pointer wrap: a grant at index NUM_REQ-1 sets the pointer to 0.
- Arithmetic is performed entirely by the ALU; the controller never modifies alu_p. All 4 select codes are legal and passed through unchanged.
- Reset mid-operation (EXEC or RESP) aborts the operation: the response is discarded and the pointer returns to 0.
- A requester that drops req_valid before its grant loses its turn with no side effects.

Test Plan:
- Single op: req 0, op=0, a=5, b=3 -> rsp_valid at accept+3 (ALU_LAT=1), rsp_data=8, rsp_id=0. Op=1 with a=3, b=5 -> rsp_data=48'hFFFF_FFFF_FFFE.
- Carry/wrap and XOR:
  - op=2, c=48'hFFFF_FFFF_FFFF, a=0, cin=1 -> rsp_data=0.
  - op=3, a=18'h3FFFF, d=18'h00FFF -> rsp_data=48'h0000_0003_F000.
- Fairness: all 4 req_valid held high with distinct operands -> grant order 0,1,2,3,0. Each response carries the matching rsp_id. req_ready is never multi-hot.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and alu_* stable; req_ready=0 throughout. Accept occurs on the first cycle rsp_ready=1.
- Reset mid-EXEC: rst_n pulsed low for 1 cycle -> all outputs 0 immediately with no response issued. With req 2 and req 3 pending afterwards, req 2 is granted first (search from pointer 0).
- Sparse requests: only req 3 valid, then only req 1 -> grants 3 then 1; pointer goes 0 -> 0 (3+1 wraps) -> 2.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one registered 48-bit ALU between
// NUM_REQ requesters. It accepts one operation at a time, holds the ALU
// operands stable for the pipeline latency, captures P and returns it with
// the ID of the requester that issued the operation.
//
// Handshakes (both channels): a transfer happens on a rising edge where
// valid and ready are both 1. A requester keeps req_valid and its operands
// stable until its req_ready bit is seen. rsp_valid stays high, with
// rsp_data and rsp_id frozen, until the edge where rsp_ready is 1.
module alu_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ALU_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [2*NUM_REQ-1:0]  req_op,
    input  logic [18*NUM_REQ-1:0] req_a,
    input  logic [18*NUM_REQ-1:0] req_b,
    input  logic [18*NUM_REQ-1:0] req_d,
    input  logic [48*NUM_REQ-1:0] req_c,
    input  logic [NUM_REQ-1:0]    req_cin,
    output logic [17:0]           alu_a,
    output logic [17:0]           alu_b,
    output logic [17:0]           alu_d,
    output logic [47:0]           alu_c,
    output logic                  alu_cin,
    output logic [1:0]            alu_select,
    input  logic [47:0]           alu_p,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [47:0]           rsp_data,
    output logic                  busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(ALU_LAT + 1);
    localparam logic [PTR_W:0]   NUM_REQ_EXT = (PTR_W + 1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(ALU_LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PTR_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [17:0]      alu_a_q;
    logic [17:0]      alu_b_q;
    logic [17:0]      alu_d_q;
    logic [47:0]      alu_c_q;
    logic             alu_cin_q;
    logic [1:0]       alu_sel_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic [47:0]      rsp_data_q;

    logic             grant_vld;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W:0]   probe;
    logic             accept;

    // Round-robin search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        probe     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            probe = {1'b0, ptr_q} + (PTR_W + 1)'(k);
            if (probe >= NUM_REQ_EXT) begin
                probe = probe - NUM_REQ_EXT;
            end
            if (!grant_vld && req_valid[probe[PTR_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = probe[PTR_W-1:0];
            end
        end
    end

    assign accept = (state_q == S_IDLE) && grant_vld;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept -> wait out the ALU pipeline -> hold response until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_vld) state_d = S_EXEC;
            S_EXEC:  if (cnt_q == CNT_LAST) state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; ready is masked while reset is asserted.
    always_comb begin
        req_ready = '0;
        if ((state_q == S_IDLE) && grant_vld && rst_n) begin
            req_ready[grant_idx] = 1'b1;
        end
        rsp_valid = (state_q == S_RESP);
        busy      = (state_q != S_IDLE);
    end

    // Datapath: operand capture on accept, latency count, result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            cnt_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_d_q    <= '0;
            alu_c_q    <= '0;
            alu_cin_q  <= 1'b0;
            alu_sel_q  <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else if (accept) begin
            alu_a_q   <= req_a[18*grant_idx +: 18];
            alu_b_q   <= req_b[18*grant_idx +: 18];
            alu_d_q   <= req_d[18*grant_idx +: 18];
            alu_c_q   <= req_c[48*grant_idx +: 48];
            alu_cin_q <= req_cin[grant_idx];
            alu_sel_q <= req_op[2*grant_idx +: 2];
            rsp_id_q  <= ID_W'(grant_idx);
            ptr_q     <= (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
            cnt_q     <= '0;
        end else if (state_q == S_EXEC) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                rsp_data_q <= alu_p;
            end
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_d      = alu_d_q;
    assign alu_c      = alu_c_q;
    assign alu_cin    = alu_cin_q;
    assign alu_select = alu_sel_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the controller
// and an external registered ALU model.
module tb_alu_share_ctrl;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int ALU_LAT = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [2*NUM_REQ-1:0]  req_op;
    logic [18*NUM_REQ-1:0] req_a, req_b, req_d;
    logic [48*NUM_REQ-1:0] req_c;
    logic [NUM_REQ-1:0]    req_cin;
    logic [17:0]           alu_a, alu_b, alu_d;
    logic [47:0]           alu_c;
    logic                  alu_cin;
    logic [1:0]            alu_select;
    logic [47:0]           alu_p;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [47:0]           rsp_data;
    logic                  busy;

    // per-requester stimulus
    logic [NUM_REQ-1:0] r_valid;
    logic [1:0]         r_op  [NUM_REQ];
    logic [17:0]        r_a   [NUM_REQ];
    logic [17:0]        r_b   [NUM_REQ];
    logic [17:0]        r_d   [NUM_REQ];
    logic [47:0]        r_c   [NUM_REQ];
    logic               r_cin [NUM_REQ];

    assign req_valid = r_valid;
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
        assign req_op[2*i +: 2]   = r_op[i];
        assign req_a[18*i +: 18]  = r_a[i];
        assign req_b[18*i +: 18]  = r_b[i];
        assign req_d[18*i +: 18]  = r_d[i];
        assign req_c[48*i +: 48]  = r_c[i];
        assign req_cin[i]         = r_cin[i];
    end

    alu_share_ctrl #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_d(req_d), .req_c(req_c), .req_cin(req_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_d(alu_d), .alu_c(alu_c),
        .alu_cin(alu_cin), .alu_select(alu_select), .alu_p(alu_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    // ---------------- external ALU model ----------------
    function automatic logic [47:0] alu_fn(input logic [1:0] op, input logic [17:0] a,
                                           input logic [17:0] b, input logic [17:0] d,
                                           input logic [47:0] c, input logic cin);
        case (op)
            2'd0:    return 48'(a) + 48'(b);
            2'd1:    return 48'(a) - 48'(b);
            2'd2:    return c + 48'(a) + 48'(cin);
            default: return 48'(a ^ d);
        endcase
    endfunction

    logic [47:0] alu_pipe [ALU_LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= alu_fn(alu_select, alu_a, alu_b, alu_d, alu_c, alu_cin);
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_p = alu_pipe[ALU_LAT-1];

    // ---------------- scoreboard / counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // transaction-level model: 0 idle, 1 executing, 2 response pending
    int          m_phase = 0;
    int          m_ptr   = 0;
    int          m_wait  = 0;
    int          m_id    = 0;
    logic [1:0]  m_op;
    logic [17:0] m_a, m_b, m_d;
    logic [47:0] m_c;
    logic        m_cin;

    int          grant_q[$];
    int          last_id;
    logic [47:0] last_data;
    int          rsp_cnt = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          lat_last = -1;
    logic        prev_rv = 1'b0;
    bit          rnd_mode = 1'b0;

    function automatic int model_grant();
        if (m_phase != 0) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx = (m_ptr + k) % NUM_REQ;
            if (r_valid[idx]) return idx;
        end
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [1:0] op, input logic [17:0] a,
                           input logic [17:0] b, input logic [17:0] d,
                           input logic [47:0] c, input logic cin);
        r_op[i] = op; r_a[i] = a; r_b[i] = b; r_d[i] = d; r_c[i] = c; r_cin[i] = cin;
        r_valid[i] = 1'b1;
    endtask

    task automatic randomize_requests();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!r_valid[i] && $urandom_range(0, 3) == 0)
                set_req(i, 2'($urandom_range(0, 3)), 18'($urandom), 18'($urandom),
                        18'($urandom), 48'({$urandom, $urandom}), 1'($urandom));
            else if (r_valid[i] && $urandom_range(0, 15) == 0)
                r_valid[i] = 1'b0;
        end
        rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    // One cycle: called at negedge; checks outputs, crosses a posedge, updates model.
    task automatic step();
        int g;
        int obs_g;
        logic [NUM_REQ-1:0] exp_ready;
        logic hs_rsp;
        #1;
        g = model_grant();
        exp_ready = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
        check("req_ready", req_ready, exp_ready);
        check("ready_onehot0", $onehot0(req_ready), 1);
        check("busy", busy, m_phase != 0);
        check("rsp_valid", rsp_valid, m_phase == 2);
        if (m_phase != 0) begin
            check("alu_a_hold", alu_a, m_a);
            check("alu_b_hold", alu_b, m_b);
            check("alu_d_hold", alu_d, m_d);
            check("alu_c_hold", alu_c, m_c);
            check("alu_cin_hold", alu_cin, m_cin);
            check("alu_sel_hold", alu_select, m_op);
        end
        if (m_phase == 2) begin
            check("rsp_data", rsp_data, alu_fn(m_op, m_a, m_b, m_d, m_c, m_cin));
            check("rsp_id", rsp_id, m_id);
        end
        obs_g = -1;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i] && r_valid[i]) obs_g = i;
        if (obs_g >= 0) begin
            grant_q.push_back(obs_g);
            acc_cyc = cyc;
        end
        if (rsp_valid && !prev_rv) lat_last = cyc - acc_cyc;
        prev_rv = rsp_valid;
        hs_rsp = rsp_valid && rsp_ready;
        if (hs_rsp) begin
            last_data = rsp_data;
            last_id   = int'(rsp_id);
            rsp_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        case (m_phase)
            0: if (g >= 0) begin
                m_op = r_op[g]; m_a = r_a[g]; m_b = r_b[g]; m_d = r_d[g];
                m_c = r_c[g]; m_cin = r_cin[g];
                m_id = g; m_ptr = (g + 1) % NUM_REQ;
                m_wait = ALU_LAT + 1; m_phase = 1;
                r_valid[g] = 1'b0;
            end
            1: begin
                m_wait--;
                if (m_wait == 0) m_phase = 2;
            end
            default: if (rsp_ready) m_phase = 0;
        endcase
        if (rnd_mode) randomize_requests();
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while ((m_phase != 0 || r_valid != '0) && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", (m_phase != 0 || r_valid != '0), 0);
    endtask

    task automatic step_until_phase(input int ph, input int budget);
        int n = 0;
        while (m_phase != ph && n < budget) begin
            step();
            n++;
        end
        check("phase_timeout", m_phase, ph);
    endtask

    // Asynchronous reset pulse of one cycle, issued at a negedge.
    task automatic do_reset_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_d", alu_d, 0);
        check("rst_alu_c", alu_c, 0);
        check("rst_alu_cin", alu_cin, 0);
        check("rst_alu_sel", alu_select, 0);
        m_phase = 0;
        m_ptr   = 0;
        prev_rv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int saved;
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        r_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            r_op[i] = '0; r_a[i] = '0; r_b[i] = '0; r_d[i] = '0; r_c[i] = '0; r_cin[i] = 1'b0;
        end
        @(negedge clk);
        do_reset_pulse();

        // single operations with known results
        set_req(0, 2'd0, 18'd5, 18'd3, 18'd0, 48'd0, 1'b0);
        run_until_done(20);
        check("add_data", last_data, 48'd8);
        check("add_id", last_id, 0);
        check("latency", lat_last, ALU_LAT + 2);

        set_req(1, 2'd1, 18'd3, 18'd5, 18'd0, 48'd0, 1'b0);
        run_until_done(20);
        check("sub_data", last_data, 48'hFFFF_FFFF_FFFE);
        check("sub_id", last_id, 1);

        set_req(2, 2'd2, 18'd0, 18'd0, 18'd0, 48'hFFFF_FFFF_FFFF, 1'b1);
        run_until_done(20);
        check("addc_wrap_data", last_data, 48'd0);

        set_req(3, 2'd3, 18'h3FFFF, 18'd0, 18'h00FFF, 48'd0, 1'b0);
        run_until_done(20);
        check("xor_data", last_data, 48'h0000_0003_F000);
        check("xor_id", last_id, 3);

        // fairness: all four pending from pointer 0
        do_reset_pulse();
        grant_q.delete();
        for (int i = 0; i < NUM_REQ; i++)
            set_req(i, 2'(i), 18'(i * 7 + 1), 18'(i * 3 + 2), 18'(i + 9), 48'(i * 1000), 1'(i));
        run_until_done(60);
        for (int i = 0; i < NUM_REQ; i++)
            set_req(i, 2'd0, 18'(i + 100), 18'(i + 200), 18'd0, 48'd0, 1'b0);
        run_until_done(60);
        check("fair_count", grant_q.size(), 2 * NUM_REQ);
        for (int i = 0; i < 5 && i < grant_q.size(); i++)
            check($sformatf("fair_order%0d", i), grant_q[i], i % NUM_REQ);

        // backpressure: hold RESP for 5 cycles with another request waiting
        set_req(0, 2'd1, 18'h2_0000, 18'h0_1234, 18'd0, 48'd0, 1'b0);
        rsp_ready = 1'b0;
        step_until_phase(2, 20);
        set_req(1, 2'd0, 18'd11, 18'd22, 18'd0, 48'd0, 1'b0);
        saved = rsp_cnt;
        for (int i = 0; i < 5; i++) step();
        check("bp_no_rsp", rsp_cnt, saved);
        rsp_ready = 1'b1;
        step();
        check("bp_rsp_taken", rsp_cnt, saved + 1);
        check("bp_data", last_data, 48'(18'h2_0000) - 48'(18'h0_1234));
        run_until_done(20);
        check("bp_next_id", last_id, 1);

        // reset mid-EXEC aborts the operation and clears the pointer
        set_req(1, 2'd0, 18'd1, 18'd1, 18'd0, 48'd0, 1'b0);
        step_until_phase(1, 20);
        saved = rsp_cnt;
        do_reset_pulse();
        check("rst_no_rsp", rsp_cnt, saved);
        grant_q.delete();
        set_req(3, 2'd0, 18'd30, 18'd3, 18'd0, 48'd0, 1'b0);
        set_req(2, 2'd0, 18'd20, 18'd2, 18'd0, 48'd0, 1'b0);
        run_until_done(40);
        check("rst_first_grant", grant_q.size() > 0 ? grant_q[0] : -1, 2);
        check("rst_rsp_count", rsp_cnt, saved + 2);

        // sparse requests and pointer wrap
        do_reset_pulse();
        grant_q.delete();
        set_req(3, 2'd0, 18'd1, 18'd2, 18'd0, 48'd0, 1'b0);
        run_until_done(20);
        set_req(1, 2'd0, 18'd3, 18'd4, 18'd0, 48'd0, 1'b0);
        run_until_done(20);
        set_req(0, 2'd0, 18'd5, 18'd6, 18'd0, 48'd0, 1'b0);
        set_req(2, 2'd0, 18'd7, 18'd8, 18'd0, 48'd0, 1'b0);
        run_until_done(40);
        check("sparse_count", grant_q.size(), 4);
        if (grant_q.size() == 4) begin
            check("sparse_g0", grant_q[0], 3);
            check("sparse_g1", grant_q[1], 1);
            check("sparse_g2", grant_q[2], 2);
            check("sparse_g3", grant_q[3], 0);
        end

        // randomized traffic with random backpressure and drops
        rnd_mode = 1'b1;
        for (int i = 0; i < 3000; i++) step();
        rnd_mode = 1'b0;
        rsp_ready = 1'b1;
        r_valid = '0;
        run_until_done(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
